// File: rtl/ncc_peak_tracker.sv
// NCC peak tracker: takes a stream of 16-row accumulator columns, one per search position.
// It reduces each column to a signed score and keeps the best (x,y) over a search window.
// The optional threshold hit counter is built only when NCC_PEAK_THRESH_EN is defined.
module ncc_peak_tracker #(
  parameter int unsigned ACC_W = 8,
  parameter int unsigned ROWS  = 16,
  parameter int unsigned NUM_X = 625,
  parameter int unsigned NUM_Y = 465,
  localparam int unsigned SCORE_W = ACC_W + $clog2(ROWS),
  localparam int unsigned XW      = $clog2(NUM_X),
  localparam int unsigned YW      = $clog2(NUM_Y)
`ifdef NCC_PEAK_THRESH_EN
  ,
  localparam int unsigned HW      = $clog2(NUM_X * NUM_Y + 1)
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ROWS*ACC_W-1:0]     acc_in,
  input  logic                      acc_valid,
`ifdef NCC_PEAK_THRESH_EN
  input  logic signed [SCORE_W-1:0] thresh,
  output logic [HW-1:0]             hit_count,
`endif
  output logic                      busy,
  output logic                      done,
  output logic signed [SCORE_W-1:0] best_score,
  output logic [XW-1:0]             best_x,
  output logic [YW-1:0]             best_y
);

  typedef enum logic [1:0] {StIdle, StScan, StFlush, StDone} state_e;

  localparam logic [XW-1:0] XLast = XW'(NUM_X - 1);
  localparam logic [YW-1:0] YLast = YW'(NUM_Y - 1);
  localparam logic signed [SCORE_W-1:0] ScoreMin = {1'b1, {(SCORE_W-1){1'b0}}};

  state_e state_q, state_d;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          arm, accept, last_beat;

  logic signed [SCORE_W-1:0] sum;

  logic                      s1_valid_q;
  logic signed [SCORE_W-1:0] s1_score_q;
  logic [XW-1:0]             s1_x_q;
  logic [YW-1:0]             s1_y_q;

  logic signed [SCORE_W-1:0] best_score_q;
  logic [XW-1:0]             best_x_q;
  logic [YW-1:0]             best_y_q;

  assign last_beat = (x_q == XLast) && (y_q == YLast);

  // Next-state logic; arm marks the accepted start, accept marks a tagged beat.
  always_comb begin
    state_d = state_q;
    arm     = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StScan;
          arm     = 1'b1;
        end
      end
      StScan: begin
        accept = acc_valid;
        if (acc_valid && last_beat) state_d = StFlush;
      end
      // Only stage 1 holds in-flight data; stage 2 writes the best registers directly.
      StFlush: if (!s1_valid_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q == StScan) || (state_q == StFlush);
  assign done = (state_q == StDone);

  // State register and raster position counters; position only moves on accepted beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      if (arm) begin
        x_q <= '0;
        y_q <= '0;
      end else if (accept) begin
        if (x_q == XLast) begin
          x_q <= '0;
          y_q <= y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
    end
  end

  // Sign-extended sum of all rows; SCORE_W leaves enough headroom that it cannot overflow.
  always_comb begin
    sum = '0;
    for (int r = 0; r < ROWS; r++) begin
      sum = sum + $signed({{(SCORE_W-ACC_W){acc_in[r*ACC_W+ACC_W-1]}},
                           acc_in[r*ACC_W +: ACC_W]});
    end
  end

  // Stage 1: register the score with its position tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_score_q <= '0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_score_q <= sum;
        s1_x_q     <= x_q;
        s1_y_q     <= y_q;
      end
    end
  end

  // Stage 2: strict greater-than keeps the earliest position on ties.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_score_q <= '0;
      best_x_q     <= '0;
      best_y_q     <= '0;
    end else if (arm) begin
      best_score_q <= ScoreMin;
      best_x_q     <= '0;
      best_y_q     <= '0;
    end else if (s1_valid_q && (s1_score_q > best_score_q)) begin
      best_score_q <= s1_score_q;
      best_x_q     <= s1_x_q;
      best_y_q     <= s1_y_q;
    end
  end

  assign best_score = best_score_q;
  assign best_x     = best_x_q;
  assign best_y     = best_y_q;

`ifdef NCC_PEAK_THRESH_EN
  logic [HW-1:0] hit_count_q;

  // Count stage-2 scores at or above the threshold for the current search.
  always_ff @(posedge clk) begin
    if (rst || arm) begin
      hit_count_q <= '0;
    end else if (s1_valid_q && (s1_score_q >= thresh)) begin
      hit_count_q <= hit_count_q + 1'b1;
    end
  end

  assign hit_count = hit_count_q;
`endif

endmodule

// File: tb/tb_ncc_peak_tracker.sv
// Scoreboard bench for ncc_peak_tracker on a 4x3 search window.
module tb_ncc_peak_tracker;

  localparam int unsigned ACC_W  = 8;
  localparam int unsigned ROWS   = 16;
  localparam int unsigned NUM_X  = 4;
  localparam int unsigned NUM_Y  = 3;
  localparam int unsigned SW     = 12;
  localparam int unsigned XW     = 2;
  localparam int unsigned YW     = 2;
  localparam int          NBEATS = 12;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [ROWS*ACC_W-1:0]   acc_in;
  logic                    acc_valid;
  logic                    busy;
  logic                    done;
  logic signed [SW-1:0]    best_score;
  logic [XW-1:0]           best_x;
  logic [YW-1:0]           best_y;
`ifdef NCC_PEAK_THRESH_EN
  logic signed [SW-1:0]    thresh;
  logic [3:0]              hit_count;
`endif

  typedef struct {
    int score;
    int x;
    int y;
    int hits;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  ncc_peak_tracker #(
    .ACC_W(ACC_W),
    .ROWS (ROWS),
    .NUM_X(NUM_X),
    .NUM_Y(NUM_Y)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .acc_in    (acc_in),
    .acc_valid (acc_valid),
`ifdef NCC_PEAK_THRESH_EN
    .thresh    (thresh),
    .hit_count (hit_count),
`endif
    .busy      (busy),
    .done      (done),
    .best_score(best_score),
    .best_x    (best_x),
    .best_y    (best_y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Builds one beat for a stimulus mode and returns its reference score.
  function automatic logic [ROWS*ACC_W-1:0] make_beat(input int mode, input int idx,
                                                      output int score);
    int rows [ROWS];
    logic [ROWS*ACC_W-1:0] v;
    for (int r = 0; r < ROWS; r++) begin
      case (mode)
        0:       rows[r] = (idx == 6 && r == 0) ? 5 : 1;
        1:       rows[r] = -128;
        2:       rows[r] = (idx == 1 || idx == 11) ? ((r < 8) ? 5 : 0) : ((r % 2) ? 3 : -1);
        3:       rows[r] = int'($urandom_range(255)) - 128;
        default: begin
          rows[r] = 0;
          if (r == 0) begin
            case (idx)
              0:       rows[r] = 10;
              3:       rows[r] = 11;
              5:       rows[r] = 50;
              8:       rows[r] = 127;
              10:      rows[r] = 20;
              2:       rows[r] = 9;
              default: rows[r] = -3;
            endcase
          end
        end
      endcase
    end
    score = 0;
    v = '0;
    for (int r = 0; r < ROWS; r++) begin
      v[r*ACC_W +: ACC_W] = rows[r][ACC_W-1:0];
      score += rows[r];
    end
    return v;
  endfunction

  task automatic run_search(input int mode, input bit gaps, input int thr);
    exp_t e;
    int   best, bx, by, hits, sc, last_cyc;
    bit   seen;
    best = -2048;
    bx = 0;
    by = 0;
    hits = 0;
    last_cyc = 0;
`ifdef NCC_PEAK_THRESH_EN
    thresh = SW'(thr);
`endif
    @(posedge clk) #1 start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    check_eq("busy_after_start", busy, 1);
    for (int i = 0; i < NBEATS; i++) begin
      if (gaps) begin
        acc_valid = 1'b0;
        acc_in = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk) #1;
      end
      acc_in = make_beat(mode, i, sc);
      acc_valid = 1'b1;
      if (sc > best) begin
        best = sc;
        bx = i % NUM_X;
        by = i / NUM_X;
      end
      if (sc >= thr) hits++;
      last_cyc = cyc;
      @(posedge clk) #1;
    end
    acc_valid = 1'b0;
    e = '{best, bx, by, hits};
    sb.push_back(e);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check_eq("done_seen", seen, 1);
    e = sb.pop_front();
    if (seen) begin
      check_eq("done_latency", cyc - last_cyc, 3);
      check_eq("busy_at_done", busy, 0);
      check_eq("best_score", best_score, e.score);
      check_eq("best_x", best_x, e.x);
      check_eq("best_y", best_y, e.y);
`ifdef NCC_PEAK_THRESH_EN
      check_eq("hit_count", hit_count, e.hits);
`endif
      // start during the done cycle must be ignored
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_eq("done_one_cycle", done, 0);
      check_eq("start_in_done_ignored", busy, 0);
      repeat (3) @(negedge clk);
      check_eq("hold_score", best_score, e.score);
      check_eq("hold_x", best_x, e.x);
      check_eq("hold_y", best_y, e.y);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    acc_valid = 1'b0;
    acc_in = '0;
`ifdef NCC_PEAK_THRESH_EN
    thresh = '0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_score", best_score, 0);
    check_eq("reset_x", best_x, 0);
    check_eq("reset_y", best_y, 0);

    // Beats without start are ignored.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk) #1;
      acc_valid = 1'($urandom_range(1));
      acc_in = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      check_eq("idle_done", done, 0);
      check_eq("idle_busy", busy, 0);
    end
    acc_valid = 1'b0;
    check_eq("idle_score", best_score, 0);
    check_eq("idle_x", best_x, 0);
    check_eq("idle_y", best_y, 0);

    run_search(0, 1'b0, 10);
    check_eq("t2_score", best_score, 20);
    check_eq("t2_x", best_x, 2);
    check_eq("t2_y", best_y, 1);

    run_search(1, 1'b0, 10);
    check_eq("t3_score", best_score, -2048);
    check_eq("t3_x", best_x, 0);
    check_eq("t3_y", best_y, 0);

    run_search(2, 1'b0, 10);
    check_eq("t4_x", best_x, 1);
    check_eq("t4_y", best_y, 0);
    run_search(2, 1'b1, 10);
    check_eq("t4g_score", best_score, 40);
    check_eq("t4g_x", best_x, 1);

    // Abort mid-search: beat 1 scores 40 and must not leak into the next run.
    @(posedge clk) #1 start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      int sc;
      acc_in = make_beat(2, i, sc);
      acc_valid = 1'b1;
      @(posedge clk) #1;
    end
    acc_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk) #1 rst = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_score", best_score, 0);
    check_eq("abort_x", best_x, 0);
    check_eq("abort_y", best_y, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("abort_no_done", done, 0);
    end
    run_search(0, 1'b0, 10);
    check_eq("t5_score", best_score, 20);

    run_search(3, 1'b0, 0);
    run_search(3, 1'b1, -50);

`ifdef NCC_PEAK_THRESH_EN
    run_search(4, 1'b0, 10);
    check_eq("t6_hits", hit_count, 5);
    @(posedge clk) #1 start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    check_eq("t6_hits_cleared", hit_count, 0);
    rst = 1'b1;
    @(posedge clk) #1 rst = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
